// File: rtl/fft_stage_sequencer.sv
// Iterative stage sequencer for the 32-point FFT: load, then issue/wait/write per butterfly stage.
// Optional status ports (cycle count, overrun flag) enabled by defining FFT_SEQ_STATUS_EN.
module fft_stage_sequencer #(
  parameter int unsigned p_stages     = 5,
  parameter int unsigned p_macLatency = 2,
  parameter int unsigned p_stageBits  = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_load_in,
  output logic                   o_issue,
  output logic                   o_wr_en,
  output logic [p_stageBits-1:0] o_stage,
  output logic [p_stages-1:0]    o_tw_step,
  output logic                   o_done
`ifdef FFT_SEQ_STATUS_EN
  ,
  output logic [15:0]            o_cycle_count,
  output logic                   o_overrun
`endif
);

  localparam int unsigned WAIT_W = $clog2(p_macLatency + 1);
  localparam logic [p_stageBits-1:0] LAST_STAGE = p_stageBits'(p_stages - 1);
  localparam logic [p_stages-1:0] TW_FIRST = p_stages'(1) << (p_stages - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                 state, state_n;
  logic [WAIT_W-1:0]      wait_cnt, wait_n;
  logic [p_stageBits-1:0] stage_n;
  logic [p_stages-1:0]    tw_n;
  logic                   start_ok;

  assign start_ok = (state == IDLE) && i_start && !i_abort;

  // Next state, counters and next values of the registered strobes
  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    stage_n = o_stage;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_n = LOAD;
          stage_n = '0;
        end
      end
      LOAD: begin
        state_n = ISSUE;
        stage_n = '0;
      end
      ISSUE: begin
        state_n = WAIT;
        wait_n  = WAIT_W'(p_macLatency);
      end
      WAIT: begin
        wait_n = wait_cnt - WAIT_W'(1);
        if (wait_cnt == WAIT_W'(1)) state_n = WRITE;
      end
      WRITE: begin
        if (o_stage == LAST_STAGE) begin
          state_n = DONE;
        end else begin
          state_n = ISSUE;
          stage_n = o_stage + p_stageBits'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Abort overrides everything outside IDLE
    if (i_abort && (state != IDLE)) begin
      state_n = IDLE;
      stage_n = '0;
      wait_n  = '0;
    end
    tw_n = TW_FIRST >> stage_n;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      o_busy    <= 1'b0;
      o_load_in <= 1'b0;
      o_issue   <= 1'b0;
      o_wr_en   <= 1'b0;
      o_done    <= 1'b0;
      o_stage   <= '0;
      o_tw_step <= TW_FIRST;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      o_busy    <= (state_n != IDLE);
      o_load_in <= (state_n == LOAD);
      o_issue   <= (state_n == ISSUE);
      o_wr_en   <= (state_n == WRITE);
      o_done    <= (state_n == DONE);
      o_stage   <= stage_n;
      o_tw_step <= tw_n;
    end
  end

`ifdef FFT_SEQ_STATUS_EN
  // Busy-cycle counter and sticky overrun flag, both restarted by an accepted start
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_cycle_count <= '0;
      o_overrun     <= 1'b0;
    end else if (start_ok) begin
      o_cycle_count <= '0;
      o_overrun     <= 1'b0;
    end else begin
      if (o_busy && (o_cycle_count != 16'hFFFF)) o_cycle_count <= o_cycle_count + 16'd1;
      if (i_start && o_busy) o_overrun <= 1'b1;
    end
  end
`endif

endmodule
